// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word type, stall counter width and helpers
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    return (cnt == STALL_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one valid+payload pipeline register with flush/advance/hold
module pipe_stage_cell #(
  parameter int WIDTH = 128
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             advance,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] payload_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] payload_out
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_out   <= 1'b0;
      payload_out <= '0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      payload_out <= '0;
    end else if (advance) begin
      valid_out   <= valid_in;
      payload_out <= payload_in;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - DEPTH-stage pipeline register with load-data capture and stall counter
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 1,
  parameter int CAPTURE = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       payload_in,
  input  word_t                  ldata_in,
  output logic                   valid_out,
  output logic [WIDTH-1:0]       payload_out,
  output word_t                  ldata_out,
  output logic                   ldata_vld,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic advance;
  assign advance = ihit & ~freeze;

  // Index 0 is the stage-0 input; index k+1 is the output of cell k.
  logic [DEPTH:0]   valid_chain;
  logic [WIDTH-1:0] payload_chain [DEPTH+1];

  assign valid_chain[0]   = valid_in;
  assign payload_chain[0] = payload_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .CLK        (CLK),
      .nRST       (nRST),
      .flush      (flush),
      .advance    (advance),
      .valid_in   (valid_chain[k]),
      .payload_in (payload_chain[k]),
      .valid_out  (valid_chain[k+1]),
      .payload_out(payload_chain[k+1])
    );
  end

  assign valid_out   = valid_chain[DEPTH];
  assign payload_out = payload_chain[DEPTH];

  if (CAPTURE != 0) begin : g_capture
    word_t ldata_reg;
    logic  ldata_vld_r;

    // Hold the first load word seen while the last stage waits; it must
    // survive memory changing ldata_in before the stage finally moves on.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        ldata_reg   <= '0;
        ldata_vld_r <= 1'b0;
      end else if (flush || advance) begin
        ldata_vld_r <= 1'b0;
      end else if (dhit && valid_out && !ldata_vld_r) begin
        ldata_reg   <= ldata_in;
        ldata_vld_r <= 1'b1;
      end
    end

    assign ldata_vld = ldata_vld_r;
    assign ldata_out = ldata_vld_r ? ldata_reg : ldata_in;
  end else begin : g_no_capture
    assign ldata_vld = 1'b0;
    assign ldata_out = ldata_in;
  end

  // A flush edge squashes the stalled instruction, so it is not counted as
  // a stall; the count itself survives the flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (freeze && valid_out && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int WIDTH = 128;
  localparam int DEPTH = 2;

  logic             CLK;
  logic             nRST;
  logic             ihit;
  logic             dhit;
  logic             freeze;
  logic             flush;
  logic             valid_in;
  logic [WIDTH-1:0] payload_in;
  logic [31:0]      ldata_in;
  logic             valid_out;
  logic [WIDTH-1:0] payload_out;
  logic [31:0]      ldata_out;
  logic             ldata_vld;
  logic [15:0]      stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [WIDTH-1:0] PAT_A = {16{8'hA5}};
  localparam logic [WIDTH-1:0] PAT_B = {16{8'h5A}};
  localparam logic [WIDTH-1:0] PAT_C = {8{16'h1234}};
  localparam logic [WIDTH-1:0] PAT_D = {4{32'h0F0F_C3C3}};

  pipe_stage_reg #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .CAPTURE(1)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .dhit       (dhit),
    .freeze     (freeze),
    .flush      (flush),
    .valid_in   (valid_in),
    .payload_in (payload_in),
    .ldata_in   (ldata_in),
    .valid_out  (valid_out),
    .payload_out(payload_out),
    .ldata_out  (ldata_out),
    .ldata_vld  (ldata_vld),
    .stall_cnt  (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b1; ihit = 0; dhit = 0; freeze = 0; flush = 0;
    valid_in = 0; payload_in = '0; ldata_in = '0;
    #2 nRST = 1'b0;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_payload", payload_out, 0);
    check("rst_ldata_vld", ldata_vld, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_ldata_out", ldata_out, 0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;

    // latency of DEPTH advances
    ihit = 1; valid_in = 1; payload_in = PAT_A;
    tick();
    check("lat_e1_valid", valid_out, 0);
    payload_in = PAT_B;
    tick();
    check("lat_e2_valid", valid_out, 1);
    check("lat_e2_payload", payload_out, PAT_A);

    // ihit low holds
    ihit = 0; payload_in = PAT_C;
    tick();
    check("hold_noihit", payload_out, PAT_A);

    // freeze for 3 cycles
    ihit = 1; freeze = 1;
    tick(); tick(); tick();
    check("frz_payload", payload_out, PAT_A);
    check("frz_stall3", stall_cnt, 3);
    freeze = 0;
    tick();
    check("frz_release", payload_out, PAT_B);
    check("frz_release_cnt", stall_cnt, 3);

    // load capture while frozen
    freeze = 1; dhit = 1; ldata_in = 32'hDEAD_BEEF;
    tick();
    check("cap_vld", ldata_vld, 1);
    ldata_in = 32'h0;
    tick();
    check("cap_hold_out", ldata_out, 32'hDEAD_BEEF);
    check("cap_hold_vld", ldata_vld, 1);
    check("cap_stall5", stall_cnt, 5);
    freeze = 0;
    tick();
    check("cap_clr_vld", ldata_vld, 0);
    ldata_in = 32'h1111_2222;
    #1;
    check("cap_bypass", ldata_out, 32'h1111_2222);
    check("cap_adv_payload", payload_out, PAT_C);

    // flush and freeze at the same edge
    freeze = 1; dhit = 1; ldata_in = 32'h0BAD_F00D;
    tick();
    check("pre_flush_vld", ldata_vld, 1);
    check("pre_flush_cnt", stall_cnt, 6);
    flush = 1;
    tick();
    check("flush_valid", valid_out, 0);
    check("flush_payload", payload_out, 0);
    check("flush_ldata_vld", ldata_vld, 0);
    check("flush_stall", stall_cnt, 6);
    flush = 0; freeze = 0; dhit = 0; valid_in = 0; payload_in = PAT_D;
    tick();
    check("flush_s0_valid", valid_out, 0);
    check("flush_s0_payload", payload_out, 0);

    // async reset during capture
    valid_in = 1;
    tick(); tick();
    check("refill_payload", payload_out, PAT_D);
    freeze = 1; dhit = 1; ldata_in = 32'hCAFE_F00D;
    tick();
    check("pre_rst_vld", ldata_vld, 1);
    ldata_in = 32'h0;
    #2 nRST = 1'b0;
    #1;
    check("arst_valid", valid_out, 0);
    check("arst_payload", payload_out, 0);
    check("arst_ldata_vld", ldata_vld, 0);
    check("arst_ldata_out", ldata_out, 0);
    check("arst_stall", stall_cnt, 0);
    #1 nRST = 1'b1;
    freeze = 0; dhit = 0;
    tick(); tick();
    check("post_rst_valid", valid_out, 1);

    // dhit together with advance must not capture
    dhit = 1; ldata_in = 32'h0000_0077;
    tick();
    check("dhit_adv_vld", ldata_vld, 0);
    dhit = 0;

    // stall counter saturation
    freeze = 1;
    for (int i = 0; i < 65534; i++) @(posedge CLK);
    #1;
    check("sat_fffe", stall_cnt, 16'hFFFE);
    tick(); tick(); tick();
    check("sat_ffff", stall_cnt, 16'hFFFF);
    freeze = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
